// File: rtl/display_scan_controller_if.sv
// Board-side bundle for the 7-segment scan controller: switch, BCD counters
// in; segment/anode drive, displayed mode and frame pulse out.
interface display_scan_controller_if;
   logic        sw_mode;
   logic [15:0] digits_A;
   logic [15:0] digits_B;
   logic [15:0] digits_C;
   logic [6:0]  segments;
   logic [7:0]  anodes;
   logic        mode_out;
   logic        frame_start;

   modport master (
      output sw_mode, digits_A, digits_B, digits_C,
      input  segments, anodes, mode_out, frame_start
   );

   modport slave (
      input  sw_mode, digits_A, digits_B, digits_C,
      output segments, anodes, mode_out, frame_start
   );
endinterface

// File: rtl/display_scan_controller.sv
// 8-digit multiplexed 7-segment scanner with per-frame snapshots and mode debounce.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros in each group.
module display_scan_controller #(
   parameter int unsigned REFRESH_DIV     = 100000,
   parameter int unsigned GUARD_CYCLES    = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input logic clk,
   input logic rst,
   display_scan_controller_if.slave bus
);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] GUARD    = DIV_W'(GUARD_CYCLES);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [15:0]      snap_a_q, snap_b_q, snap_c_q;
   logic             mode_q;
   logic             sync1_q, sync2_q, stable_q;
   logic [DB_W-1:0]  db_cnt_q;
   logic             frame_q;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;

   logic             boundary;
   logic [15:0]      grp;
   logic [1:0]       pos;
   logic [3:0]       nib;
   logic             blank;

   assign boundary = (div_q == '0) && (idx_q == 3'd0);

   always_comb begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = idx_q + 3'd1;
      end
   end

   // Upper four slots show A (mode 0) or nothing (mode 1); lower show B or C.
   always_comb begin
      grp   = '0;
      blank = 1'b0;
      pos   = idx_q[1:0];
      unique case (1'b1)
         !mode_q &&  idx_q[2]: grp = snap_a_q;
         !mode_q && !idx_q[2]: grp = snap_b_q;
          mode_q && !idx_q[2]: grp = snap_c_q;
         default:              blank = 1'b1;
      endcase
      nib = 4'(grp >> {pos, 2'b00});
`ifdef LEADING_ZERO_BLANK_EN
      if (pos != 2'd0 && (grp >> {pos, 2'b00}) == 16'h0)
         blank = 1'b1;
`endif
   end

   always_comb begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      if (div_q >= GUARD && !blank) begin
         an_d = ~(8'b1 << idx_q);
         case (nib)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            default: seg_d = 7'b0001110;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= '0;
         idx_q    <= 3'd0;
         snap_a_q <= '0;
         snap_b_q <= '0;
         snap_c_q <= '0;
         mode_q   <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         db_cnt_q <= '0;
         frame_q  <= 1'b0;
         an_q     <= 8'hFF;
         seg_q    <= 7'h7F;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         sync1_q <= bus.sw_mode;
         sync2_q <= sync1_q;
         if (sync2_q == stable_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DB_LAST) begin
            stable_q <= ~stable_q;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
         end
         frame_q <= boundary;
         if (boundary) begin
            snap_a_q <= bus.digits_A;
            snap_b_q <= bus.digits_B;
            snap_c_q <= bus.digits_C;
            mode_q   <= stable_q;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign bus.segments    = seg_q;
   assign bus.anodes      = an_q;
   assign bus.mode_out    = mode_q;
   assign bus.frame_start = frame_q;
endmodule
